// File: rtl/bp_amplitude_meter.sv
// Peak-to-peak amplitude meter for the bandpass filter output.
// Measures max/min over fixed sample windows and hands results out on valid/ready.
module bp_amplitude_meter #(
    parameter int DATA_W = 12,
    parameter int WINDOW = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W:0]   r_pp,
    output logic [DATA_W-1:0] r_max,
    output logic [DATA_W-1:0] r_min,
    output logic              r_clip,
    output logic              r_overrun
);

    localparam int CNT_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    localparam logic signed [DATA_W-1:0] FS_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] FS_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [0:0]               state;
    logic [CNT_W-1:0]         cnt;
    logic signed [DATA_W-1:0] cur_max;
    logic signed [DATA_W-1:0] cur_min;
    logic                     clip_acc;

    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] nxt_max;
    logic signed [DATA_W-1:0] nxt_min;
    logic signed [DATA_W:0]   pp_wide;
    logic                     is_clip;
    logic                     clip_nxt;
    logic                     closing;

    // Running extremes including the current sample; the first sample seeds both.
    always_comb begin
        sample  = $signed(s_data);
        is_clip = (sample == FS_POS) || (sample == FS_NEG);
        nxt_max = sample;
        nxt_min = sample;
        if (state == S_ACCUM) begin
            nxt_max = (sample > cur_max) ? sample : cur_max;
            nxt_min = (sample < cur_min) ? sample : cur_min;
        end
        clip_nxt = ((state == S_ACCUM) && clip_acc) || is_clip;
        closing  = s_valid && (state == S_ACCUM) && (cnt == LAST);
        pp_wide  = {nxt_max[DATA_W-1], nxt_max} - {nxt_min[DATA_W-1], nxt_min};
    end

    // Window accumulator: seed, update, and close back to EMPTY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_EMPTY;
            cnt      <= '0;
            cur_max  <= '0;
            cur_min  <= '0;
            clip_acc <= 1'b0;
        end else if (clear) begin
            state    <= S_EMPTY;
            cnt      <= '0;
            clip_acc <= 1'b0;
        end else if (s_valid) begin
            if (closing) begin
                state    <= S_EMPTY;
                cnt      <= '0;
                clip_acc <= 1'b0;
            end else begin
                state    <= S_ACCUM;
                cnt      <= cnt + 1'b1;
                cur_max  <= nxt_max;
                cur_min  <= nxt_min;
                clip_acc <= clip_nxt;
            end
        end
    end

    // Single-entry result register; a close over an unread result flags overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_pp      <= '0;
            r_max     <= '0;
            r_min     <= '0;
            r_clip    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (clear) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (closing) begin
            r_valid   <= 1'b1;
            r_pp      <= pp_wide;
            r_max     <= nxt_max;
            r_min     <= nxt_min;
            r_clip    <= clip_nxt;
            r_overrun <= r_valid && !r_ready;
        end else if (r_valid && r_ready) begin
            r_valid   <= 1'b0;
            r_pp      <= '0;
            r_max     <= '0;
            r_min     <= '0;
            r_clip    <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

endmodule
